dmem_hs_ctrl: RTL

Parametrised successor to the byte-addressed data memory. It is a big-endian data memory of 2^ADDR_W bytes supporting byte, half-word and word accesses. Requests and responses use valid/ready handshakes, with a configurable number of wait states and optional sign extension on loads. Misaligned or illegal accesses return an error instead of being silently performed. It sits in the MEM stage of the pipeline, between the ALU result/store-data path and writeback.

---
 rtl/dmem_hs_if.sv | 25 ++
 rtl/dmem_hs_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dmem_hs_if.sv
// Request/response handshake bundle for the MEM-stage data memory.
// The master issues requests and consumes responses; the slave is the memory.
interface dmem_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_hs_ctrl.sv
// Big-endian byte-addressed data memory with valid/ready request and response
// handshakes, programmable wait states and alignment checking.
module dmem_hs_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input logic       clk,
  input logic       reset_n,
  dmem_hs_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                accept, perform, err_p0, mem_we;
  logic                write_p0, signed_p0;
  logic [1:0]          size_p0;
  logic [ADDR_W-1:0]   addr_p0, addr1_p0, addr2_p0, addr3_p0;
  logic [31:0]         wdata_p0, word_p0;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [7:0]          mem [2**ADDR_W];

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sext,
                                              input logic [31:0] word);
    logic fill;
    fill = sext & word[31];
    case (size)
      2'b00:   extend_load = {{24{fill}}, word[31:24]};
      2'b01:   extend_load = {{16{fill}}, word[31:16]};
      default: extend_load = word;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    perform       = 1'b0;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = reset_n;
        accept        = bus.req_valid & reset_n;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          perform   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: fields are frozen at acceptance so later req_* changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0  <= bus.req_write;
      size_p0   <= bus.req_size;
      signed_p0 <= bus.req_signed;
      addr_p0   <= bus.req_addr[ADDR_W-1:0];
      wdata_p0  <= bus.req_wdata;
    end
  end

  // Byte lanes wrap modulo the memory depth
  assign addr1_p0 = addr_p0 + ADDR_W'(1);
  assign addr2_p0 = addr_p0 + ADDR_W'(2);
  assign addr3_p0 = addr_p0 + ADDR_W'(3);
  assign word_p0  = {mem[addr_p0], mem[addr1_p0], mem[addr2_p0], mem[addr3_p0]};
  assign err_p0   = (size_p0 == 2'b11) ||
                    ((size_p0 == 2'b01) && addr_p0[0]) ||
                    ((size_p0 == 2'b10) && (addr_p0[1:0] != 2'b00));
  assign mem_we   = perform & write_p0 & ~err_p0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (size_p0)
        2'b00: mem[addr_p0] <= wdata_p0[7:0];
        2'b01: begin
          mem[addr_p0]  <= wdata_p0[15:8];
          mem[addr1_p0] <= wdata_p0[7:0];
        end
        2'b10: begin
          mem[addr_p0]  <= wdata_p0[31:24];
          mem[addr1_p0] <= wdata_p0[23:16];
          mem[addr2_p0] <= wdata_p0[15:8];
          mem[addr3_p0] <= wdata_p0[7:0];
        end
        default: ;
      endcase
    end
  end

  // Wait-state counter and registered response, stable for the whole RESP phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept)                              cnt <= 4'(LATENCY);
      else if (state == BUSY && cnt != 4'd0)   cnt <= cnt - 4'd1;
      if (perform) begin
        err_q   <= err_p0;
        rdata_q <= (err_p0 || write_p0) ? 32'd0 : extend_load(size_p0, signed_p0, word_p0);
      end
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
